// File: rtl/sd_cmd_arbiter.sv
// Arbitrates the SD command-host write port between software and the data master.
// Holds the grant from the write strobe until the host has started and then finished the command.
module sd_cmd_arbiter #(
  parameter int ARG_W    = 32,
  parameter int SET_W    = 16,
  parameter int TOUT_W   = 16,
  parameter int TOUT_CYC = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_req,
  input  logic [ARG_W-1:0] sw_arg,
  input  logic [SET_W-1:0] sw_set,
  output logic             sw_ack,
  output logic             sw_err,
  input  logic             dm_req,
  input  logic [ARG_W-1:0] dm_arg,
  input  logic [SET_W-1:0] dm_set,
  output logic             dm_ack,
  input  logic             dm_lock,
  output logic [ARG_W-1:0] cmd_arg,
  output logic [SET_W-1:0] cmd_set,
  output logic             cmd_we,
  input  logic             cmd_busy,
  output logic             owner,
  output logic             arb_busy,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_END} state_e;

  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_CYC - 1);
  localparam logic [TOUT_W-1:0] TIMER_MAX = '1;

  state_e             state_q, state_d;
  logic [TOUT_W-1:0]  timer_q, timer_d;
  logic               dm_mask_q, dm_mask_d;
  logic               sw_mask_q, sw_mask_d;
  logic               owner_q, owner_d;
  logic [ARG_W-1:0]   arg_q, arg_d;
  logic [SET_W-1:0]   set_q, set_d;

  logic dm_elig, sw_elig, grant, grant_dm, tout_hit;

  assign dm_elig  = dm_req & ~dm_mask_q;
  assign sw_elig  = sw_req & ~sw_mask_q & ~dm_lock;
  assign grant    = (state_q == IDLE) & ~cmd_busy & (dm_elig | sw_elig);
  // On a tie the grant alternates away from whoever was served last.
  assign grant_dm = dm_elig & (~sw_elig | ~owner_q);
  assign tout_hit = (timer_q == TOUT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      dm_mask_q <= 1'b0;
      sw_mask_q <= 1'b0;
      owner_q   <= 1'b0;
      arg_q     <= '0;
      set_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      dm_mask_q <= dm_mask_d;
      sw_mask_q <= sw_mask_d;
      owner_q   <= owner_d;
      arg_q     <= arg_d;
      set_q     <= set_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    owner_d   = owner_q;
    arg_d     = arg_q;
    set_d     = set_q;
    // A mask survives only while its request stays high.
    dm_mask_d = dm_mask_q & dm_req;
    sw_mask_d = sw_mask_q & sw_req;
    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d = grant_dm;
          arg_d   = grant_dm ? dm_arg : sw_arg;
          set_d   = grant_dm ? dm_set : sw_set;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        if (owner_q) dm_mask_d = 1'b1;
        else         sw_mask_d = 1'b1;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (cmd_busy)                 state_d = WAIT_END;
        else if (tout_hit)            state_d = IDLE;
        else if (timer_q != TIMER_MAX) timer_d = timer_q + TOUT_W'(1);
      end
      WAIT_END: begin
        if (!cmd_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_we   = (state_q == ISSUE);
    sw_ack   = cmd_we & ~owner_q;
    dm_ack   = cmd_we & owner_q;
    timeout  = (state_q == WAIT_START) & ~cmd_busy & tout_hit;
    sw_err   = timeout & ~owner_q;
    arb_busy = (state_q != IDLE);
    owner    = owner_q;
    cmd_arg  = arg_q;
    cmd_set  = set_q;
  end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Bench for sd_cmd_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of the arbiter.
module tb_sd_cmd_arbiter;
  localparam int ARG_W    = 32;
  localparam int SET_W    = 16;
  localparam int TOUT_W   = 16;
  localparam int TOUT_CYC = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             sw_req, dm_req, dm_lock, cmd_busy;
  logic [ARG_W-1:0] sw_arg, dm_arg, cmd_arg;
  logic [SET_W-1:0] sw_set, dm_set, cmd_set;
  logic             sw_ack, sw_err, dm_ack, cmd_we, owner, arb_busy, timeout;

  sd_cmd_arbiter #(.ARG_W(ARG_W), .SET_W(SET_W), .TOUT_W(TOUT_W), .TOUT_CYC(TOUT_CYC)) dut (
    .clk(clk), .rst(rst),
    .sw_req(sw_req), .sw_arg(sw_arg), .sw_set(sw_set), .sw_ack(sw_ack), .sw_err(sw_err),
    .dm_req(dm_req), .dm_arg(dm_arg), .dm_set(dm_set), .dm_ack(dm_ack),
    .dm_lock(dm_lock), .cmd_arg(cmd_arg), .cmd_set(cmd_set), .cmd_we(cmd_we),
    .cmd_busy(cmd_busy), .owner(owner), .arb_busy(arb_busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: an occupied flag plus the age of the current command.
  bit               m_occ, m_started, m_owner, m_dm_msk, m_sw_msk;
  int               m_age;
  logic [ARG_W-1:0] m_arg;
  logic [SET_W-1:0] m_set;

  // Host and requester emulation
  bit host_auto, host_rand, rereq;
  int host_dly_cfg, host_len_cfg, host_dly, host_left, dm_cnt, sw_cnt;
  int we_cnt, sw_ack_cnt, dm_ack_cnt;
  int grant_log[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_started = 0; m_owner = 0; m_dm_msk = 0; m_sw_msk = 0;
    m_age = 0; m_arg = '0; m_set = '0;
  endtask

  task automatic step();
    bit e_we, e_to, dm_e, sw_e, g_dm, n_dm_msk, n_sw_msk;
    @(negedge clk);
    if (!rst) begin
      model_reset();
      host_left = 0; host_dly = 0;
    end
    e_we = m_occ && (m_age == 0);
    e_to = m_occ && !m_started && !cmd_busy && (m_age == TOUT_CYC);
    check_val("cmd_we",   cmd_we,   e_we);
    check_val("sw_ack",   sw_ack,   e_we && !m_owner);
    check_val("dm_ack",   dm_ack,   e_we && m_owner);
    check_val("arb_busy", arb_busy, m_occ);
    check_val("timeout",  timeout,  e_to);
    check_val("sw_err",   sw_err,   e_to && !m_owner);
    check_val("owner",    owner,    m_owner);
    check_val("cmd_arg",  cmd_arg,  m_arg);
    check_val("cmd_set",  cmd_set,  m_set);
    if (cmd_we) begin
      we_cnt++;
      grant_log.push_back(int'(dm_ack));
      if (host_auto) begin
        host_dly  = host_rand ? int'($urandom_range(0, 10)) : host_dly_cfg;
        host_left = host_rand ? int'($urandom_range(1, 6))  : host_len_cfg;
      end
    end
    if (sw_ack) sw_ack_cnt++;
    if (dm_ack) dm_ack_cnt++;
    if (rereq) begin
      if (dm_ack) dm_cnt = 3;
      if (sw_ack) sw_cnt = 3;
    end
    if (rst) begin
      n_dm_msk = (e_we && m_owner)  ? 1'b1 : (m_dm_msk && dm_req);
      n_sw_msk = (e_we && !m_owner) ? 1'b1 : (m_sw_msk && sw_req);
      if (!m_occ) begin
        dm_e = dm_req && !m_dm_msk;
        sw_e = sw_req && !m_sw_msk && !dm_lock;
        if (!cmd_busy && (dm_e || sw_e)) begin
          g_dm = dm_e && (!sw_e || !m_owner);
          m_occ = 1; m_age = 0; m_started = 0; m_owner = g_dm;
          m_arg = g_dm ? dm_arg : sw_arg;
          m_set = g_dm ? dm_set : sw_set;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (!m_started) begin
        if (cmd_busy)                m_started = 1;
        else if (m_age == TOUT_CYC)  m_occ = 0;
        else                         m_age++;
      end else if (!cmd_busy) begin
        m_occ = 0;
      end
      m_dm_msk = n_dm_msk;
      m_sw_msk = n_sw_msk;
    end
    @(posedge clk);
    #1;
    if (host_auto) begin
      if (host_dly > 0) begin host_dly--; cmd_busy = 1'b0; end
      else if (host_left > 0) begin cmd_busy = 1'b1; host_left--; end
      else cmd_busy = 1'b0;
    end
    if (dm_cnt > 0) begin dm_cnt--; dm_req = (dm_cnt != 1); end
    if (sw_cnt > 0) begin sw_cnt--; sw_req = (sw_cnt != 1); end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sw_req = 0; dm_req = 0; dm_lock = 0; cmd_busy = 0;
    host_auto = 0; host_rand = 0; rereq = 0; dm_cnt = 0; sw_cnt = 0;
    run(2);
    rst = 1'b1;
    we_cnt = 0; sw_ack_cnt = 0; dm_ack_cnt = 0;
    grant_log.delete();
  endtask

  initial begin
    sw_arg = '0; sw_set = '0; dm_arg = '0; dm_set = '0;
    host_dly_cfg = 0; host_len_cfg = 1; host_dly = 0; host_left = 0;
    model_reset();
    do_reset();
    check_val("rst_outs", {cmd_we, sw_ack, dm_ack, sw_err, timeout, arb_busy, owner, cmd_arg, cmd_set}, 64'd0);

    // Software-only command
    host_auto = 1; host_dly_cfg = 0; host_len_cfg = 3;
    sw_req = 1; sw_arg = 32'h0000_1000; sw_set = 16'h111A;
    step();
    check_val("t2_we", cmd_we, 1'b1);
    check_val("t2_ack", sw_ack, 1'b1);
    check_val("t2_arg", cmd_arg, 32'h0000_1000);
    check_val("t2_set", cmd_set, 16'h111A);
    check_val("t2_owner", owner, 1'b0);
    sw_req = 0;
    run(8);

    // Tie: both requesters keep coming back, host busy 5 cycles each
    do_reset();
    host_auto = 1; host_dly_cfg = 0; host_len_cfg = 5; rereq = 1;
    dm_arg = 32'hD000_0011; dm_set = 16'h0D11; sw_arg = 32'h5000_0022; sw_set = 16'h0522;
    dm_req = 1; sw_req = 1;
    run(40);
    check_val("t3_count", grant_log.size() >= 4, 1'b1);
    check_val("t3_g0", grant_log[0], 1);
    check_val("t3_g1", grant_log[1], 0);
    check_val("t3_g2", grant_log[2], 1);
    check_val("t3_g3", grant_log[3], 0);

    // Lock blocks software but not the data master
    do_reset();
    host_auto = 1; host_dly_cfg = 1; host_len_cfg = 5;
    dm_lock = 1; sw_req = 1;
    run(40);
    dm_req = 1; run(2); dm_req = 0;
    run(58);
    check_val("t4_no_sw", sw_ack_cnt, 0);
    check_val("t4_dm", dm_ack_cnt, 1);
    dm_lock = 0;
    step();
    check_val("t4_sw_after", sw_ack, 1'b1);
    sw_req = 0;
    run(10);

    // Start timeout: host never goes busy
    do_reset();
    sw_arg = 32'hCAFE_0005; sw_req = 1;
    step();
    check_val("t5_ack", sw_ack, 1'b1);
    sw_req = 0;
    run(7);
    check_val("t5_early", timeout, 1'b0);
    step();
    check_val("t5_tout", timeout, 1'b1);
    check_val("t5_err", sw_err, 1'b1);
    step();
    check_val("t5_idle", arb_busy, 1'b0);

    // Request held past its ack is not re-issued
    do_reset();
    host_auto = 1; host_dly_cfg = 0; host_len_cfg = 1;
    dm_req = 1;
    step();
    check_val("t6_ack", dm_ack, 1'b1);
    run(4);
    dm_req = 0;
    run(5);
    check_val("t6_once", we_cnt, 1);
    dm_req = 1;
    run(2);
    check_val("t6_again", we_cnt, 2);
    dm_req = 0;
    run(6);

    // Reset in the middle of a data-master command
    do_reset();
    host_auto = 1; host_dly_cfg = 0; host_len_cfg = 20;
    dm_arg = 32'h1234_5678; dm_req = 1;
    step();
    run(3);
    check_val("t1_busy", arb_busy, 1'b1);
    rst = 0;
    #1;
    check_val("t1_rst_outs", {cmd_we, sw_ack, dm_ack, sw_err, timeout, arb_busy, owner, cmd_arg, cmd_set}, 64'd0);
    step();
    rst = 1;
    step();
    check_val("t1_regrant", dm_ack, 1'b1);
    check_val("t1_owner", owner, 1'b1);
    dm_req = 0;
    run(25);

    // Random traffic
    do_reset();
    host_auto = 1; host_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)  dm_req  = ~dm_req;
      if ($urandom_range(0, 3) == 0)  sw_req  = ~sw_req;
      if ($urandom_range(0, 19) == 0) dm_lock = ~dm_lock;
      sw_arg = $urandom; dm_arg = $urandom;
      sw_set = SET_W'($urandom); dm_set = SET_W'($urandom);
      rst = ($urandom_range(0, 599) != 0);
      step();
    end
    rst = 1;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
